// File: rtl/ex_mem_reg_pkg.sv
// Shared CPU package: opcode encodings, EX/MEM FSM states, drain counter sizing.
package ex_mem_reg_pkg;

    localparam int unsigned OPC_W = 4;
    localparam int unsigned CNT_W = 2;

    // Edges spent in DRAIN after HLT before HALTED is entered
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(2);

    typedef enum logic [OPC_W-1:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_XOR    = 4'b0010,
        OP_RED    = 4'b0011,
        OP_SLL    = 4'b0100,
        OP_SRA    = 4'b0101,
        OP_ROR    = 4'b0110,
        OP_PADDSB = 4'b0111,
        OP_LW     = 4'b1000,
        OP_SW     = 4'b1001,
        OP_LHB    = 4'b1010,
        OP_LLB    = 4'b1011,
        OP_B      = 4'b1100,
        OP_BR     = 4'b1101,
        OP_PCS    = 4'b1110,
        OP_HLT    = 4'b1111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_HALTED  = 2'd2
    } state_e;

endpackage

// File: rtl/ex_mem_reg_if.sv
// EX -> MEM pipeline bus.
//   master: EX-stage producer, drives ex_*, observes mem_*
//   slave : pipeline register, consumes ex_*, drives mem_*
interface ex_mem_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4
);
    import ex_mem_reg_pkg::*;

    logic              ex_valid;
    logic [OPC_W-1:0]  ex_opcode;
    logic [DATA_W-1:0] ex_alu_result;
    logic              ex_alu_ovfl;
    logic [DATA_W-1:0] ex_store_data;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;

    logic              mem_valid;
    logic [OPC_W-1:0]  mem_opcode;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_store_data;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_reg_write;
    logic              mem_mem_read;
    logic              mem_mem_write;

    modport master (
        output ex_valid, ex_opcode, ex_alu_result, ex_alu_ovfl, ex_store_data,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
        input  mem_valid, mem_opcode, mem_alu_result, mem_store_data, mem_rd,
               mem_reg_write, mem_mem_read, mem_mem_write
    );

    modport slave (
        input  ex_valid, ex_opcode, ex_alu_result, ex_alu_ovfl, ex_store_data,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
        output mem_valid, mem_opcode, mem_alu_result, mem_store_data, mem_rd,
               mem_reg_write, mem_mem_read, mem_mem_write
    );

endinterface

// File: rtl/ex_mem_reg_flag_reg.sv
// Architectural Z/V/N flag register, written only when upd_en is set.
//   clk, rst_n : clock, async active-low reset
//   upd_en     : a real instruction is being captured this edge
//   opcode     : captured opcode, selects which flags change
//   result     : ALU result
//   ovfl       : ALU signed overflow
//   flag_z/v/n : registered flags
module flag_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              upd_en,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [DATA_W-1:0] result,
    input  logic              ovfl,
    output logic              flag_z,
    output logic              flag_v,
    output logic              flag_n
);

    logic z_q, z_d, v_q, v_d, n_q, n_d;

    // Flag selection: Z for arith/logic/shift, N and V for ADD/SUB only
    always_comb begin
        z_d = z_q;
        v_d = v_q;
        n_d = n_q;
        if (upd_en) begin
            case (opcode_e'(opcode))
                OP_ADD, OP_SUB: begin
                    z_d = (result == '0);
                    n_d = result[DATA_W-1];
                    v_d = ovfl;
                end
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: z_d = (result == '0);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q <= 1'b0;
            v_q <= 1'b0;
            n_q <= 1'b0;
        end else begin
            z_q <= z_d;
            v_q <= v_d;
            n_q <= n_d;
        end
    end

    assign flag_z = z_q;
    assign flag_v = v_q;
    assign flag_n = n_q;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/flush, condition flags and HLT drain FSM.
//   clk, rst_n     : clock, async active-low reset
//   stall          : hold every register
//   flush          : load a bubble (overrides stall)
//   bus            : ex_* in, mem_* out (registered copies)
//   flag_z/v/n     : architectural flags
//   halted         : pipeline drained after HLT
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     stall,
    input  logic     flush,
    ex_mem_if.slave  bus,
    output logic     flag_z,
    output logic     flag_v,
    output logic     flag_n,
    output logic     halted
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              halted_q, halted_d;

    logic              valid_q, valid_d;
    logic [OPC_W-1:0]  opcode_q, opcode_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] sdata_q, sdata_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              rw_q, rw_d;
    logic              mr_q, mr_d;
    logic              mw_q, mw_d;

    logic              capture_c;
    logic              bubble_c;

    assign capture_c = !stall && !flush && bus.ex_valid && (state_q == ST_RUN);
    assign bubble_c  = flush || (!stall && !capture_c);

    // Next-state: pipeline payload, drain FSM and counter
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        opcode_d = opcode_q;
        result_d = result_q;
        sdata_d  = sdata_q;
        rd_d     = rd_q;
        rw_d     = rw_q;
        mr_d     = mr_q;
        mw_d     = mw_q;

        if (capture_c) begin
            valid_d  = 1'b1;
            opcode_d = bus.ex_opcode;
            result_d = bus.ex_alu_result;
            sdata_d  = bus.ex_store_data;
            rd_d     = bus.ex_rd;
            rw_d     = bus.ex_reg_write;
            mr_d     = bus.ex_mem_read;
            mw_d     = bus.ex_mem_write;
        end else if (bubble_c) begin
            // Bubble kills control only; data fields keep their old contents
            valid_d = 1'b0;
            rw_d    = 1'b0;
            mr_d    = 1'b0;
            mw_d    = 1'b0;
        end

        case (state_q)
            ST_RUN: begin
                if (capture_c && (opcode_e'(bus.ex_opcode) == OP_HLT)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                // Counter runs 2 -> 1 -> 0, third unstalled edge halts
                if (!stall) begin
                    if (cnt_q == '0) state_d = ST_HALTED;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase

        halted_d = (state_d == ST_HALTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            valid_q  <= 1'b0;
            opcode_q <= '0;
            result_q <= '0;
            sdata_q  <= '0;
            rd_q     <= '0;
            rw_q     <= 1'b0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            result_q <= result_d;
            sdata_q  <= sdata_d;
            rd_q     <= rd_d;
            rw_q     <= rw_d;
            mr_q     <= mr_d;
            mw_q     <= mw_d;
        end
    end

    flag_reg #(.DATA_W(DATA_W)) u_flag_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .upd_en (capture_c),
        .opcode (bus.ex_opcode),
        .result (bus.ex_alu_result),
        .ovfl   (bus.ex_alu_ovfl),
        .flag_z (flag_z),
        .flag_v (flag_v),
        .flag_n (flag_n)
    );

    assign bus.mem_valid      = valid_q;
    assign bus.mem_opcode     = opcode_q;
    assign bus.mem_alu_result = result_q;
    assign bus.mem_store_data = sdata_q;
    assign bus.mem_rd         = rd_q;
    assign bus.mem_reg_write  = rw_q;
    assign bus.mem_mem_read   = mr_q;
    assign bus.mem_mem_write  = mw_q;
    assign halted             = halted_q;

endmodule
